fdtd_mem_word_wr: RTL

- AXI4 write master that turns a simple single-word write request (word address, data, byte enables) into one single-beat AXI4 write transaction.
- Counterpart of the FDTD word-read master. The FDTD engine writes field-grid results back to shared memory through it.
- Holds one outstanding transaction at a time. Latches the request, drives AW and W independently, and grants on the write response.

---
 rtl/fdtd_axi_pkg.sv | 29 ++
 rtl/fdtd_mem_word_wr.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fdtd_axi_pkg.sv
// rtl/fdtd_axi_pkg.sv - shared AXI4 constants and write-master state type
//
// Purpose : AXI4 response/burst encodings and the FDTD word-write FSM state
//           type, imported by the FDTD memory masters.
// Contents: RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR, wr_state_e,
//           resp_is_err() helper.
package fdtd_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef enum logic [2:0] {
      WS_IDLE,
      WS_AW_W,
      WS_AW,
      WS_W,
      WS_B
   } wr_state_e;

   // Both error encodings have the upper bit set.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/fdtd_mem_word_wr.sv
// rtl/fdtd_mem_word_wr.sv - single-word AXI4 write master for the FDTD engine
//
// Purpose : turns a level write request (word address, data, byte enables)
//           into one single-beat AXI4 write; one transaction outstanding.
// Ports   : ACLK / ARESETn (async, active-low)
//           AW*  : address channel, AWADDR_o = {word addr, 2'b00}, rest tied
//           W*   : data channel, WLAST_o tied high
//           B*   : response channel, BID_i/BUSER_i ignored
//           wr_req_i/wr_word_addr_i/wr_data_i/wr_be_i : request side
//           wr_gnt_o : one-cycle pulse when the write response is accepted
// Option  : FDTD_WR_BRESP_CHECK_EN adds wr_err_o, pulsing with wr_gnt_o on a
//           SLVERR/DECERR response; otherwise BRESP_i is unused.
module fdtd_mem_word_wr
   import fdtd_axi_pkg::*;
#(
   parameter int AXI4_ADDR_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH = 32,
   parameter int AXI4_ID_WIDTH   = 16,
   parameter int AXI4_USER_WIDTH = 10,
   parameter int AXI_STRB_WIDTH  = AXI4_DATA_WIDTH/8
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   // write address channel
   output logic [AXI4_ID_WIDTH-1:0]     AWID_o,
   output logic [AXI4_ADDR_WIDTH-1:0]   AWADDR_o,
   output logic [7:0]                   AWLEN_o,
   output logic [2:0]                   AWSIZE_o,
   output logic [1:0]                   AWBURST_o,
   output logic                         AWLOCK_o,
   output logic [3:0]                   AWCACHE_o,
   output logic [2:0]                   AWPROT_o,
   output logic [3:0]                   AWREGION_o,
   output logic [3:0]                   AWQOS_o,
   output logic [AXI4_USER_WIDTH-1:0]   AWUSER_o,
   output logic                         AWVALID_o,
   input  logic                         AWREADY_i,
   // write data channel
   output logic [AXI4_DATA_WIDTH-1:0]   WDATA_o,
   output logic [AXI_STRB_WIDTH-1:0]    WSTRB_o,
   output logic                         WLAST_o,
   output logic [AXI4_USER_WIDTH-1:0]   WUSER_o,
   output logic                         WVALID_o,
   input  logic                         WREADY_i,
   // write response channel
   input  logic [AXI4_ID_WIDTH-1:0]     BID_i,
   input  logic [1:0]                   BRESP_i,
   input  logic [AXI4_USER_WIDTH-1:0]   BUSER_i,
   input  logic                         BVALID_i,
   output logic                         BREADY_o,
   // request side
   input  logic                         wr_req_i,
   input  logic [AXI4_ADDR_WIDTH-3:0]   wr_word_addr_i,
   input  logic [AXI4_DATA_WIDTH-1:0]   wr_data_i,
   input  logic [AXI_STRB_WIDTH-1:0]    wr_be_i,
`ifdef FDTD_WR_BRESP_CHECK_EN
   output logic                         wr_err_o,
`endif
   output logic                         wr_gnt_o
);

   wr_state_e                        state;
   logic [AXI4_ADDR_WIDTH-3:0]       addr_q;
   logic [AXI4_DATA_WIDTH-1:0]       data_q;
   logic [AXI_STRB_WIDTH-1:0]        strb_q;
   logic                             awvalid_q;
   logic                             wvalid_q;
   logic                             bready_q;

   assign AWID_o     = '0;
   assign AWLEN_o    = 8'd0;
   assign AWSIZE_o   = 3'd2;
   assign AWBURST_o  = BURST_INCR;
   assign AWLOCK_o   = 1'b0;
   assign AWCACHE_o  = 4'd0;
   assign AWPROT_o   = 3'd0;
   assign AWREGION_o = 4'd0;
   assign AWQOS_o    = 4'd0;
   assign AWUSER_o   = '0;
   assign WLAST_o    = 1'b1;
   assign WUSER_o    = '0;

   assign AWADDR_o  = {addr_q, 2'b00};
   assign WDATA_o   = data_q;
   assign WSTRB_o   = strb_q;
   assign AWVALID_o = awvalid_q;
   assign WVALID_o  = wvalid_q;
   assign BREADY_o  = bready_q;

   // Responses arriving outside WS_B are neither accepted nor granted.
   assign wr_gnt_o = BVALID_i & (state == WS_B);

`ifdef FDTD_WR_BRESP_CHECK_EN
   assign wr_err_o = wr_gnt_o & resp_is_err(BRESP_i);
   logic unused_b;
   assign unused_b = ^{BID_i, BUSER_i};
`else
   logic unused_b;
   assign unused_b = ^{BID_i, BUSER_i, BRESP_i};
`endif

   // Valids are registered: they rise the cycle after the request is latched
   // and fall on the edge that completes their own handshake, so AW and W
   // retire independently in any order.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state     <= WS_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
      end else begin
         case (state)
            WS_IDLE: begin
               if (wr_req_i) begin
                  addr_q    <= wr_word_addr_i;
                  data_q    <= wr_data_i;
                  strb_q    <= wr_be_i;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  state     <= WS_AW_W;
               end
            end
            WS_AW_W: begin
               case ({AWREADY_i, WREADY_i})
                  2'b11: begin
                     awvalid_q <= 1'b0;
                     wvalid_q  <= 1'b0;
                     bready_q  <= 1'b1;
                     state     <= WS_B;
                  end
                  2'b10: begin
                     awvalid_q <= 1'b0;
                     state     <= WS_W;
                  end
                  2'b01: begin
                     wvalid_q  <= 1'b0;
                     state     <= WS_AW;
                  end
                  default: ;
               endcase
            end
            WS_AW: begin
               if (AWREADY_i) begin
                  awvalid_q <= 1'b0;
                  bready_q  <= 1'b1;
                  state     <= WS_B;
               end
            end
            WS_W: begin
               if (WREADY_i) begin
                  wvalid_q <= 1'b0;
                  bready_q <= 1'b1;
                  state    <= WS_B;
               end
            end
            WS_B: begin
               if (BVALID_i) begin
                  bready_q <= 1'b0;
                  state    <= WS_IDLE;
               end
            end
            default: begin
               awvalid_q <= 1'b0;
               wvalid_q  <= 1'b0;
               bready_q  <= 1'b0;
               state     <= WS_IDLE;
            end
         endcase
      end
   end

endmodule
